// File: rtl/up_dn_counter_lim.sv
// rtl/up_dn_counter_lim.sv - up/down counter with programmable limits, step, saturate/wrap mode
module up_dn_counter_lim #(
    parameter int WIDTH = 5,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] IN,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    output logic [WIDTH-1:0] counter,
    output logic             high,
    output logic             low,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0]        counter_q, counter_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic [WIDTH:0]          sum;
    logic signed [WIDTH:0]   diff;
    logic                    up_cross, dn_cross, lim_ok;

    // One extra bit keeps carries and borrows visible to the limit compares.
    assign sum      = {1'b0, counter_q} + {1'b0, step};
    assign diff     = $signed({1'b0, counter_q}) - $signed({1'b0, step});
    assign up_cross = sum > {1'b0, hi_lim};
    assign dn_cross = diff < $signed({1'b0, lo_lim});
    assign lim_ok   = lo_lim <= hi_lim;

    assign high    = counter_q >= hi_lim;
    assign low     = counter_q <= lo_lim;
    assign counter = counter_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    always_comb begin
        counter_d = counter_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (load) begin
            counter_d = IN;
        end else if (en && lim_ok && (step != '0)) begin
            // Down has priority; an ignored down does not fall through to up.
            if (down) begin
                if (WRAP || !low) begin
                    if (dn_cross) begin
                        counter_d = WRAP ? hi_lim : lo_lim;
                        unf_d     = 1'b1;
                    end else begin
                        counter_d = diff[WIDTH-1:0];
                    end
                end
            end else if (up) begin
                if (WRAP || !high) begin
                    if (up_cross) begin
                        counter_d = WRAP ? lo_lim : hi_lim;
                        ovf_d     = 1'b1;
                    end else begin
                        counter_d = sum[WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

endmodule
